// File: rtl/spi_periph_bus_bridge_pkg.sv
// spi_periph_bus_bridge_pkg: shared widths, error byte and FSM encoding for the bridge
package spi_periph_bus_bridge_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 8'hFF;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_BUS = 3'd1;
  localparam logic [2:0] WR_ACK = 3'd2;
  localparam logic [2:0] RD_BUS = 3'd3;
  localparam logic [2:0] RD_ACK = 3'd4;
endpackage

// File: rtl/spi_periph_bus_bridge_sync_level.sv
// spi_periph_bus_bridge_sync_level: multi-flop level synchronizer for an asynchronous handshake line
module spi_periph_bus_bridge_sync_level #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  // shift the raw level through the chain; left unreset so a level held across reset stays visible
  always_ff @(posedge clk_i) ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_periph_bus_bridge.sv
// spi_periph_bus_bridge: turns spi_periph four-phase byte handshakes into strobe/ack bus accesses with timeout
module spi_periph_bus_bridge
  import spi_periph_bus_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              wr_done_o,
  input  logic              data_req_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              data_rd_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic wr_s, req_s, arm_wr, arm_rd, expired;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  spi_periph_bus_bridge_sync_level #(.STAGES(SYNC_STAGES)) u_sync_wr (.clk_i(clk_i), .d(data_wr_i), .q(wr_s));
  spi_periph_bus_bridge_sync_level #(.STAGES(SYNC_STAGES)) u_sync_rd (.clk_i(clk_i), .d(data_req_i), .q(req_s));
  // the strobe has been up for TIMEOUT cycles once this edge passes without ack
  assign expired = cnt == LAST;
  // a request only becomes serviceable after its line has been seen low since reset
  always_ff @(posedge clk_i) begin
    arm_wr <= rst_i ? 1'b0 : arm_wr | ~wr_s;
    arm_rd <= rst_i ? 1'b0 : arm_rd | ~req_s;
  end
  // handshake and bus access sequencing; write wins over a simultaneous read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_done_o   <= 1'b0;
      data_rd_o   <= 1'b0;
      bus_stb_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= ERR_DATA;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (wr_s && arm_wr) begin
            bus_addr_o  <= addr_i;
            bus_wdata_o <= wdata_i;
            bus_we_o    <= 1'b1;
            bus_stb_o   <= 1'b1;
            state       <= WR_BUS;
          end else if (req_s && arm_rd) begin
            bus_addr_o <= addr_i;
            bus_we_o   <= 1'b0;
            bus_stb_o  <= 1'b1;
            state      <= RD_BUS;
          end
        end
        WR_BUS, RD_BUS: begin
          cnt <= cnt + CW'(1);
          if (bus_ack_i || expired) begin
            bus_stb_o <= 1'b0;
            err_o     <= ~bus_ack_i;
            if (state == RD_BUS) begin
              rdata_o   <= bus_ack_i ? bus_rdata_i : ERR_DATA;
              data_rd_o <= 1'b1;
              state     <= RD_ACK;
            end else begin
              wr_done_o <= 1'b1;
              state     <= WR_ACK;
            end
          end
        end
        WR_ACK: if (!wr_s) begin
          wr_done_o <= 1'b0;
          state     <= IDLE;
        end
        RD_ACK: if (!req_s) begin
          data_rd_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_periph_bus_bridge.sv
// tb_spi_periph_bus_bridge: directed checks of handshake, bus access, timeout and reset behaviour
module tb_spi_periph_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_wr = 1'b0;
  logic data_req = 1'b0;
  logic [7:0] wdata = '0;
  logic [15:0] addr = '0;
  logic [7:0] bus_rdata = '0;
  logic ack_a = 1'b0;
  logic ack_b = 1'b0;
  logic wr_done_a, data_rd_a, stb_a, we_a, err_a;
  logic [7:0] rdata_a, bwdata_a;
  logic [15:0] baddr_a;
  logic wr_done_b, data_rd_b, stb_b, we_b, err_b;
  logic [7:0] rdata_b, bwdata_b;
  logic [15:0] baddr_b;
  int total = 0;
  int passed = 0;
  int errs_a = 0;
  int errs_b = 0;
  logic seen;

  always #5 clk = ~clk;

  spi_periph_bus_bridge dut_a (
    .clk_i(clk), .rst_i(rst), .data_wr_i(data_wr), .wdata_i(wdata), .addr_i(addr),
    .wr_done_o(wr_done_a), .data_req_i(data_req), .rdata_o(rdata_a), .data_rd_o(data_rd_a),
    .bus_stb_o(stb_a), .bus_we_o(we_a), .bus_addr_o(baddr_a), .bus_wdata_o(bwdata_a),
    .bus_rdata_i(bus_rdata), .bus_ack_i(ack_a), .err_o(err_a)
  );

  spi_periph_bus_bridge #(.TIMEOUT(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_wr_i(data_wr), .wdata_i(wdata), .addr_i(addr),
    .wr_done_o(wr_done_b), .data_req_i(data_req), .rdata_o(rdata_b), .data_rd_o(data_rd_b),
    .bus_stb_o(stb_b), .bus_we_o(we_b), .bus_addr_o(baddr_b), .bus_wdata_o(bwdata_b),
    .bus_rdata_i(bus_rdata), .bus_ack_i(ack_b), .err_o(err_b)
  );

  always @(negedge clk) begin
    if (err_a) errs_a++;
    if (err_b) errs_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [7:0] rd);
    bus_rdata = rd;
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_wr_done"}, wr_done_a, 0);
    chk({tag, "_data_rd"}, data_rd_a, 0);
    chk({tag, "_stb"}, stb_a, 0);
    chk({tag, "_we"}, we_a, 0);
    chk({tag, "_err"}, err_a, 0);
    chk({tag, "_rdata"}, rdata_a, 8'hFF);
    chk({tag, "_addr"}, baddr_a, 16'h0000);
    chk({tag, "_wdata"}, bwdata_a, 8'h00);
  endtask

  initial begin
    tick(3);
    check_reset_a("rst");
    rst = 1'b0;
    tick(4);

    // write with immediate ack
    addr = 16'h4C4C; wdata = 8'h3C; data_wr = 1'b1;
    tick(2);
    chk("wr_stb_early", stb_a, 0);
    tick();
    chk("wr_stb", stb_a, 1);
    chk("wr_we", we_a, 1);
    chk("wr_addr", baddr_a, 16'h4C4C);
    chk("wr_wdata", bwdata_a, 8'h3C);
    pulse_a(8'h00);
    chk("wr_done_hi", wr_done_a, 1);
    chk("wr_stb_drop", stb_a, 0);
    data_wr = 1'b0;
    tick(2);
    chk("wr_done_hold", wr_done_a, 1);
    tick();
    chk("wr_done_lo", wr_done_a, 0);
    tick(12);

    // read acked after 20 cycles
    errs_a = 0;
    addr = 16'hF0F0; data_req = 1'b1;
    tick(3);
    chk("rd_stb", stb_a, 1);
    chk("rd_we", we_a, 0);
    chk("rd_addr", baddr_a, 16'hF0F0);
    tick(19);
    chk("rd_stb_wait", stb_a, 1);
    chk("rd_data_rd_wait", data_rd_a, 0);
    pulse_a(8'hA5);
    chk("rd_data_rd_hi", data_rd_a, 1);
    chk("rd_rdata", rdata_a, 8'hA5);
    chk("rd_stb_drop", stb_a, 0);
    data_req = 1'b0;
    tick(3);
    chk("rd_data_rd_lo", data_rd_a, 0);
    chk("rd_rdata_hold", rdata_a, 8'hA5);
    chk("rd_no_err", errs_a, 0);
    tick(12);

    // read timeout on the TIMEOUT=8 instance
    errs_b = 0;
    addr = 16'h1234; data_req = 1'b1;
    tick(3);
    chk("rto_stb", stb_b, 1);
    tick(7);
    chk("rto_stb_hold", stb_b, 1);
    tick();
    chk("rto_stb_drop", stb_b, 0);
    chk("rto_err", err_b, 1);
    chk("rto_rdata", rdata_b, 8'hFF);
    chk("rto_data_rd", data_rd_b, 1);
    tick();
    chk("rto_err_pulse", err_b, 0);
    pulse_a(8'h00);
    data_req = 1'b0;
    tick(4);
    chk("rto_data_rd_lo", data_rd_b, 0);
    chk("rto_err_count", errs_b, 1);
    tick(8);

    // write timeout on the TIMEOUT=8 instance
    errs_b = 0;
    addr = 16'h5678; wdata = 8'h77; data_wr = 1'b1;
    tick(3);
    chk("wto_stb", stb_b, 1);
    chk("wto_we", we_b, 1);
    tick(8);
    chk("wto_stb_drop", stb_b, 0);
    chk("wto_err", err_b, 1);
    chk("wto_wr_done", wr_done_b, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | stb_b;
    end
    chk("wto_no_restrobe", seen, 0);
    chk("wto_err_count", errs_b, 1);
    pulse_a(8'h00);
    data_wr = 1'b0;
    tick(12);

    // simultaneous write and read: write first, read after write handshake
    addr = 16'h00AA; wdata = 8'h11; data_wr = 1'b1; data_req = 1'b1;
    tick(3);
    chk("sim_wr_stb", stb_a, 1);
    chk("sim_wr_we", we_a, 1);
    pulse_a(8'h00);
    chk("sim_wr_done", wr_done_a, 1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | stb_a;
    end
    chk("sim_rd_held", seen, 0);
    data_wr = 1'b0;
    tick(3);
    chk("sim_wr_done_lo", wr_done_a, 0);
    chk("sim_rd_not_yet", stb_a, 0);
    tick();
    chk("sim_rd_stb", stb_a, 1);
    chk("sim_rd_we", we_a, 0);
    pulse_a(8'h5A);
    chk("sim_rd_data_rd", data_rd_a, 1);
    chk("sim_rd_rdata", rdata_a, 8'h5A);
    data_req = 1'b0;
    tick(20);

    // reset during a read with the request held high
    addr = 16'h0BEE; data_req = 1'b1;
    tick(3);
    chk("rst_rd_stb", stb_a, 1);
    tick(2);
    rst = 1'b1;
    tick();
    check_reset_a("mid_rst");
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | stb_a;
    end
    chk("rst_no_strobe", seen, 0);
    data_req = 1'b0;
    tick(4);
    addr = 16'h0BEF; data_req = 1'b1;
    tick(3);
    chk("rst_rd2_stb", stb_a, 1);
    chk("rst_rd2_addr", baddr_a, 16'h0BEF);
    pulse_a(8'hC3);
    chk("rst_rd2_data_rd", data_rd_a, 1);
    chk("rst_rd2_rdata", rdata_a, 8'hC3);
    data_req = 1'b0;
    tick(3);
    chk("rst_rd2_data_rd_lo", data_rd_a, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
